// File: rtl/pic_pkg.sv
// Shared types and ICW bit positions for the PIC init/ack sequencer.
// Pure declarations; no logic, no latency, no backpressure.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT = 3'd0,
    W_ICW2 = 3'd1,
    W_ICW3 = 3'd2,
    W_ICW4 = 3'd3,
    READY  = 3'd4
  } init_state_t;

  typedef enum logic [1:0] {
    A_IDLE = 2'd0,
    A_FRZ  = 2'd1,
    A_DRV  = 2'd2
  } ack_state_t;

  localparam int ICW1_SEL_BIT = 4;
  localparam int SNGL_BIT     = 1;
  localparam int IC4_BIT      = 0;
  localparam int AEOI_BIT     = 1;

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index-wins priority encoder with valid flag.
// Purely combinational, zero latency; no backpressure.
module pic_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int IDW     = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [IDW-1:0]     id,
  output logic               vld
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    id  = '0;
    vld = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        id  = IDW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_init_ack_seq.sv
// ICW init sequencer plus two-pulse INTA vector driver; vector on bus the cycle after the 2nd INTA.
// No backpressure; optional auto-EOI pulse enabled by macro PIC_AEOI_EN.
module pic_init_ack_seq
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDW     = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_stb,
  input  logic               a0,
  input  logic [7:0]         din,
  input  logic               inta_stb,
  input  logic [NUM_IRQ-1:0] isr,
  output logic [7:0]         dout,
  output logic               dout_en,
  output logic               init_done,
  output logic               freeze,
  output logic               eoi_stb,
  output logic [IDW-1:0]     eoi_id
);

  init_state_t init_state, init_next;
  ack_state_t  ack_state, ack_next;

  logic [7:0] icw1, icw2, icw3, icw4;
  logic [7:0] vec_q;
  logic       is_icw1;
  logic       wr_icw2, wr_icw3, wr_icw4;
  logic       load_vec;

  logic [IDW-1:0] enc_id;
  logic           enc_vld;
  logic [IDW-1:0] sel_id;

  pic_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDW     (IDW)
  ) u_prio_enc (
    .req (isr),
    .id  (enc_id),
    .vld (enc_vld)
  );

  // Empty in-service vector reports the spurious (highest) level.
  assign sel_id  = enc_vld ? enc_id : IDW'(NUM_IRQ - 1);
  assign is_icw1 = wr_stb & ~a0 & din[ICW1_SEL_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_state <= UNINIT;
      ack_state  <= A_IDLE;
    end else begin
      init_state <= init_next;
      ack_state  <= ack_next;
    end
  end

  always_comb begin
    init_next = init_state;
    wr_icw2   = 1'b0;
    wr_icw3   = 1'b0;
    wr_icw4   = 1'b0;
    if (is_icw1) begin
      init_next = W_ICW2;
    end else begin
      case (init_state)
        W_ICW2: if (wr_stb && a0) begin
          wr_icw2 = 1'b1;
          if (!icw1[SNGL_BIT])    init_next = W_ICW3;
          else if (icw1[IC4_BIT]) init_next = W_ICW4;
          else                    init_next = READY;
        end
        W_ICW3: if (wr_stb && a0) begin
          wr_icw3   = 1'b1;
          init_next = icw1[IC4_BIT] ? W_ICW4 : READY;
        end
        W_ICW4: if (wr_stb && a0) begin
          wr_icw4   = 1'b1;
          init_next = READY;
        end
        default: init_next = init_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icw1 <= '0;
      icw2 <= '0;
      icw3 <= '0;
      icw4 <= '0;
    end else if (is_icw1) begin
      icw1 <= din;
      icw2 <= '0;
      icw3 <= '0;
      icw4 <= '0;
    end else begin
      if (wr_icw2) icw2 <= din;
      if (wr_icw3) icw3 <= din;
      if (wr_icw4) icw4 <= din;
    end
  end

  assign init_done = (init_state == READY);

  // A fresh ICW1 aborts any acknowledge cycle in progress.
  always_comb begin
    ack_next = ack_state;
    load_vec = 1'b0;
    if (is_icw1) begin
      ack_next = A_IDLE;
    end else begin
      case (ack_state)
        A_IDLE: if (inta_stb && init_done) ack_next = A_FRZ;
        A_FRZ: if (inta_stb && init_done) begin
          ack_next = A_DRV;
          load_vec = 1'b1;
        end
        A_DRV:   ack_next = A_IDLE;
        default: ack_next = A_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        vec_q <= '0;
    else if (load_vec) vec_q <= {icw2[7:IDW], sel_id};
  end

  assign dout_en = (ack_state == A_DRV);
  assign freeze  = (ack_state == A_FRZ) || (ack_state == A_DRV);
  assign dout    = dout_en ? vec_q : 8'h00;

`ifdef PIC_AEOI_EN
  assign eoi_stb = dout_en & icw4[AEOI_BIT];
  assign eoi_id  = eoi_stb ? vec_q[IDW-1:0] : '0;
`else
  assign eoi_stb = 1'b0;
  assign eoi_id  = '0;
`endif

  // Configuration bits kept for completeness but not consumed by this block.
  logic unused_cfg;
  assign unused_cfg = ^{icw1, icw2[IDW-1:0], icw3, icw4};

endmodule

// File: tb/tb_pic_init_ack_seq.sv
// Directed bench: 8-line and 16-line instances share the CPU/INTA stimulus, separate isr inputs.
module tb_pic_init_ack_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_stb = 1'b0;
  logic        a0 = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        inta_stb = 1'b0;
  logic [7:0]  isr8 = 8'h00;
  logic [15:0] isr16 = 16'h0000;

  logic [7:0]  dout8, dout16;
  logic        dout_en8, dout_en16;
  logic        init_done8, init_done16;
  logic        freeze8, freeze16;
  logic        eoi_stb8, eoi_stb16;
  logic [2:0]  eoi_id8;
  logic [3:0]  eoi_id16;

  int n_total = 0;
  int n_bad   = 0;

`ifdef PIC_AEOI_EN
  localparam bit AEOI_ON = 1'b1;
`else
  localparam bit AEOI_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pic_init_ack_seq #(.NUM_IRQ(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .a0(a0), .din(din),
    .inta_stb(inta_stb), .isr(isr8), .dout(dout8), .dout_en(dout_en8),
    .init_done(init_done8), .freeze(freeze8), .eoi_stb(eoi_stb8), .eoi_id(eoi_id8)
  );

  pic_init_ack_seq #(.NUM_IRQ(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .a0(a0), .din(din),
    .inta_stb(inta_stb), .isr(isr16), .dout(dout16), .dout_en(dout_en16),
    .init_done(init_done16), .freeze(freeze16), .eoi_stb(eoi_stb16), .eoi_id(eoi_id16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [7:0] d);
    @(negedge clk);
    wr_stb = 1'b1;
    a0     = sel;
    din    = d;
    @(negedge clk);
    wr_stb = 1'b0;
    a0     = 1'b0;
    din    = 8'h00;
  endtask

  task automatic inta();
    @(negedge clk);
    inta_stb = 1'b1;
    @(negedge clk);
    inta_stb = 1'b0;
  endtask

  // Leaves the caller at the falling edge inside the vector-drive cycle.
  task automatic ack2();
    inta();
    inta();
  endtask

  initial begin
    #12;
    check("rst_init_done", init_done8, 0);
    check("rst_dout_en", dout_en8, 0);
    check("rst_dout", dout8, 8'h00);
    check("rst_freeze", freeze8, 0);
    check("rst_eoi_stb", eoi_stb8, 0);
    check("rst_eoi_id", eoi_id8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    inta();
    check("uninit_inta_freeze", freeze8, 0);
    inta();
    check("uninit_inta_dout_en", dout_en8, 0);

    wr(1'b0, 8'h13);
    check("icw1_init_done", init_done8, 0);
    wr(1'b1, 8'h40);
    check("icw2_init_done", init_done8, 0);
    wr(1'b1, 8'h03);
    check("icw4_init_done", init_done8, 1);
    check("icw4_init_done16", init_done16, 1);

    isr8 = 8'h20;
    inta();
    check("frz_freeze", freeze8, 1);
    check("frz_dout_en", dout_en8, 0);
    check("frz_dout", dout8, 8'h00);
    inta();
    check("drv_dout_en", dout_en8, 1);
    check("drv_dout", dout8, 8'h45);
    check("drv_eoi_stb", eoi_stb8, AEOI_ON ? 1 : 0);
    check("drv_eoi_id", eoi_id8, AEOI_ON ? 5 : 0);
    check("drv_dout16_spur", dout16, 8'h4F);
    @(negedge clk);
    check("post_dout_en", dout_en8, 0);
    check("post_dout", dout8, 8'h00);
    check("post_freeze", freeze8, 0);
    check("post_eoi_stb", eoi_stb8, 0);

    wr(1'b0, 8'h0A);
    check("ready_ocw_init_done", init_done8, 1);
    wr(1'b1, 8'hFF);
    check("ready_a0_init_done", init_done8, 1);
    isr8 = 8'h06;
    ack2();
    check("lowbit_dout", dout8, 8'h41);
    inta_stb = 1'b1;
    @(negedge clk);
    inta_stb = 1'b0;
    check("drv_inta_freeze", freeze8, 0);
    check("drv_inta_dout_en", dout_en8, 0);

    isr8 = 8'h00;
    ack2();
    check("spur8_dout", dout8, 8'h47);

    inta();
    check("abort_freeze_pre", freeze8, 1);
    wr(1'b0, 8'h13);
    check("abort_freeze", freeze8, 0);
    check("abort_init_done", init_done8, 0);
    inta();
    check("abort_dout_en", dout_en8, 0);
    check("abort_freeze2", freeze8, 0);

    wr(1'b0, 8'h08);
    check("ign_ocw_init_done", init_done8, 0);
    wr(1'b1, 8'h80);
    check("icw2b_init_done", init_done8, 0);
    wr(1'b1, 8'h01);
    check("icw4b_init_done", init_done8, 1);
    isr8  = 8'h04;
    isr16 = 16'h0000;
    ack2();
    check("spur16_dout", dout16, 8'h8F);
    check("spur16_dout_en", dout_en16, 1);
    check("id2_dout", dout8, 8'h82);
    check("noaeoi_eoi_stb", eoi_stb8, 0);
    isr16 = 16'h0400;
    ack2();
    check("id10_dout16", dout16, 8'h8A);

    wr(1'b0, 8'h11);
    wr(1'b1, 8'h48);
    wr(1'b1, 8'h00);
    check("icw3_init_done", init_done8, 0);
    wr(1'b1, 8'h03);
    check("casc_init_done", init_done8, 1);
    isr8 = 8'h08;
    ack2();
    check("casc_dout", dout8, 8'h4B);
    check("casc_dout_en", dout_en8, 1);
    rst_n = 1'b0;
    #1;
    check("arst_dout_en", dout_en8, 0);
    check("arst_dout", dout8, 8'h00);
    check("arst_init_done", init_done8, 0);
    check("arst_eoi_stb", eoi_stb8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    wr(1'b0, 8'h11);
    wr(1'b1, 8'h40);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("w3rst_init_done", init_done8, 0);
    check("w3rst_freeze", freeze8, 0);
    check("w3rst_dout_en", dout_en8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(1'b1, 8'h40);
    wr(1'b1, 8'h00);
    wr(1'b1, 8'h03);
    check("w3rst_noicw1_init_done", init_done8, 0);
    ack2();
    check("w3rst_inta_dout_en", dout_en8, 0);

    wr(1'b0, 8'h12);
    wr(1'b1, 8'h40);
    check("single_noic4_init_done", init_done8, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pic_init_ack_seq.md
PIC_INIT_ACK_SEQ -- requirements
Module: pic_init_ack_seq

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of interrupt lines; legal values 4, 8, 16.
REQ-002 Parameter IDW, default $clog2(NUM_IRQ), width of the interrupt-id field.
REQ-003 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-004 Port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 Port wr_stb  in  1  one-cycle synchronous CPU write strobe.
REQ-006 Port a0  in  1  register select, qualified by wr_stb.
REQ-007 Port din  in  8  CPU write data.
REQ-008 Port inta_stb  in  1  one-cycle pulse per INTA assertion, pre-synchronised.
REQ-009 Port isr  in  NUM_IRQ  in-service vector from the priority block.
REQ-010 Port dout  out  8  vector byte to data bus.
REQ-011 Port dout_en  out  1  bus direction; 1 drives dout.
REQ-012 Port init_done  out  1  initialisation sequence complete.
REQ-013 Port freeze  out  1  IRR freeze between first and second INTA.
REQ-014 Port eoi_stb  out  1  one-cycle auto-EOI request.
REQ-015 Port eoi_id  out  IDW  level cleared by eoi_stb.

Function
REQ-016 Init FSM states: UNINIT, W_ICW2, W_ICW3, W_ICW4, READY.
REQ-017 wr_stb with a0=0 and din[4]=1 is ICW1 in any state: latch icw1, clear icw2..icw4, deassert init_done, go W_ICW2 next cycle.
REQ-018 W_ICW2: wr_stb with a0=1 latches icw2; next state W_ICW3 if icw1[1]=0, else W_ICW4 if icw1[0]=1, else READY.
REQ-019 W_ICW3: wr_stb with a0=1 latches icw3; next W_ICW4 if icw1[0]=1, else READY.
REQ-020 W_ICW4: wr_stb with a0=1 latches icw4; next READY.
REQ-021 In W_ICW2/3/4, wr_stb with a0=0 and din[4]=0 is ignored; state unchanged.
REQ-022 In UNINIT and READY, writes other than ICW1 do not change init state.
REQ-023 init_done=1 exactly while state is READY.
REQ-024 Ack FSM states: A_IDLE, A_FRZ, A_DRV; advances only on inta_stb while init_done=1.
REQ-025 A_IDLE + inta_stb -> A_FRZ; freeze=1 from next cycle; dout_en stays 0.
REQ-026 A_FRZ + inta_stb -> A_DRV; dout = {icw2[7:IDW], id}, dout_en=1 from next cycle.
REQ-027 id = index of lowest-numbered set bit of isr, sampled at the A_FRZ->A_DRV transition; isr all-zero gives id = NUM_IRQ-1 (spurious).
REQ-028 A_DRV holds dout/dout_en for exactly one cycle, then A_IDLE with freeze=0, dout_en=0.
REQ-029 inta_stb while in A_DRV is ignored.
REQ-030 inta_stb while init_done=0 is ignored; dout_en stays 0.
REQ-031 ICW1 during A_FRZ or A_DRV forces A_IDLE, freeze=0, dout_en=0 next cycle.
REQ-032 dout = 8'h00 whenever dout_en=0.

Reset
REQ-033 rst_n low asynchronously forces UNINIT, A_IDLE, icw1..icw4=0, dout=0, dout_en=0, freeze=0, init_done=0, eoi_stb=0, eoi_id=0.
REQ-034 Deassertion takes effect at the first rising clk edge with rst_n high; no output glitches during reset.

Configuration
REQ-035 Macro PIC_AEOI_EN defined: when icw4[1]=1, eoi_stb pulses one cycle in the A_DRV cycle with eoi_id = id driven.
REQ-036 PIC_AEOI_EN undefined: icw4[1] stored but ignored; eoi_stb and eoi_id constant 0.

Structure
REQ-037 Shared package pic_pkg holds init-state and ack-state enums and constants ICW1_SEL_BIT=4, SNGL_BIT=1, IC4_BIT=0, AEOI_BIT=1.
REQ-038 Sub-module pic_prio_enc: parametrised NUM_IRQ lowest-index priority encoder with valid flag.

Verification
REQ-039 NUM_IRQ=8: ICW1=0x13 (single, IC4), ICW2=0x40, ICW4=0x03 -> init_done=1 after third write; no ICW3 state visited.
REQ-040 After REQ-039 init, isr=0x20, two inta_stb -> freeze after first, dout=0x45 with dout_en=1 for one cycle after second.
REQ-041 PIC_AEOI_EN, same sequence -> eoi_stb=1, eoi_id=5 coincident with dout_en.
REQ-042 NUM_IRQ=16, ICW2=0x80, isr=0 -> spurious vector dout=0x8F.
REQ-043 ICW1 issued between the two inta_stb pulses -> freeze=0, dout_en never asserts, init_done=0.
REQ-044 rst_n asserted in W_ICW3 -> all outputs 0 immediately; subsequent ICW2 write without ICW1 ignored.
